// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 4-bit processor and its instruction loader.
//   INSTR_W        : instruction word width
//   NOP_WORD       : instruction used to pad unused instruction-memory words
//   LOAD/ADD/SUB/NOP : opcode field values (instruction bits [7:6])
//   loader_state_t : states of the instruction loader FSM
// -----------------------------------------------------------------------------
package proc_pkg;

   localparam int INSTR_W = 8;

   localparam logic [INSTR_W-1:0] NOP_WORD = 8'b11_00_0000;

   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] ADD  = 2'b01;
   localparam logic [1:0] SUB  = 2'b10;
   localparam logic [1:0] NOP  = 2'b11;

   typedef enum logic [2:0] {
      LEN,
      DATA,
      CSUM,
      FILL,
      DONE,
      ERROR
   } loader_state_t;

   // Opcode field of an instruction word.
   function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1 -: 2];
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
// Byte stream carrying a program image into the instruction loader.
//   in_valid : stream byte valid           (master -> slave)
//   in_data  : stream byte                 (master -> slave)
//   in_ready : loader can accept a byte    (slave -> master)
// Modports: master = host/boot side, slave = loader side.
// -----------------------------------------------------------------------------
interface instr_loader_if;
   import proc_pkg::*;

   logic               in_valid;
   logic [INSTR_W-1:0] in_data;
   logic               in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Writer side of the processor's instruction memory. Receives a program image
// as LEN, N instruction bytes, CSUM over the byte stream, writes the bytes to
// addresses 0..N-1, checks length and checksum, and keeps the processor in
// reset until the image is complete.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   s_in      : byte stream (instr_loader_if.slave)
//   restart   : pulse; re-arms the loader from DONE or ERROR
//   mem_we    : instruction-memory write enable (registered)
//   mem_addr  : write address (registered)
//   mem_wdata : write data (registered)
//   cpu_reset : processor reset, low only in DONE
//   done      : image loaded and verified
//   error     : bad length or checksum mismatch
//
// Build option: LOADER_NOP_FILL_EN
//   defined   : after a good checksum, words N..DEPTH-1 are written with
//               NOP_WORD (one per cycle) before DONE.
//   undefined : a good checksum goes straight to DONE; words N..DEPTH-1 keep
//               their previous contents.
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int         DEPTH    = 32,
   parameter int         AW       = $clog2(DEPTH),
   parameter logic [7:0] NOP_WORD = proc_pkg::NOP_WORD
) (
   input  logic            clk,
   input  logic            reset,
   instr_loader_if.slave   s_in,
   input  logic            restart,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [7:0]      mem_wdata,
   output logic            cpu_reset,
   output logic            done,
   output logic            error
);
   import proc_pkg::*;

   localparam logic [7:0]  DEPTH_B  = 8'(DEPTH);
   localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

   loader_state_t state_reg, state_next;
   // Pointer and length are one bit wider than the address so N == DEPTH fits.
   logic [AW:0]   len_reg, len_next;
   logic [AW:0]   wr_ptr_reg, wr_ptr_next;
   logic [7:0]    sum_reg, sum_next;
   logic          mem_we_reg, mem_we_next;
   logic [AW-1:0] mem_addr_reg, mem_addr_next;
   logic [7:0]    mem_wdata_reg, mem_wdata_next;

   logic ready;
   logic xfer;

   assign ready = !reset && (state_reg == LEN || state_reg == DATA || state_reg == CSUM);
   assign xfer  = s_in.in_valid && ready;

   assign s_in.in_ready = ready;
   assign mem_we        = mem_we_reg;
   assign mem_addr      = mem_addr_reg;
   assign mem_wdata     = mem_wdata_reg;
   assign done          = (state_reg == DONE);
   assign error         = (state_reg == ERROR);
   assign cpu_reset     = (state_reg != DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= LEN;
         len_reg       <= '0;
         wr_ptr_reg    <= '0;
         sum_reg       <= '0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         wr_ptr_reg    <= wr_ptr_next;
         sum_reg       <= sum_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      wr_ptr_next    = wr_ptr_reg;
      sum_next       = sum_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      case (state_reg)
         LEN: begin
            if (xfer) begin
               if (s_in.in_data == 8'd0 || s_in.in_data > DEPTH_B) begin
                  state_next = ERROR;
               end else begin
                  len_next    = s_in.in_data[AW:0];
                  wr_ptr_next = '0;
                  sum_next    = '0;
                  state_next  = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               mem_we_next    = 1'b1;
               mem_addr_next  = wr_ptr_reg[AW-1:0];
               mem_wdata_next = s_in.in_data;
               sum_next       = sum_reg + s_in.in_data;
               wr_ptr_next    = wr_ptr_reg + 1'b1;
               if (wr_ptr_reg == len_reg - 1'b1) begin
                  state_next = CSUM;
               end
            end
         end
         CSUM: begin
            if (xfer) begin
               if (s_in.in_data == sum_reg) begin
`ifdef LOADER_NOP_FILL_EN
                  // wr_ptr already equals N here, so FILL starts at address N.
                  state_next = (len_reg < DEPTH_P) ? FILL : DONE;
`else
                  state_next = DONE;
`endif
               end else begin
                  state_next = ERROR;
               end
            end
         end
         FILL: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = wr_ptr_reg[AW-1:0];
            mem_wdata_next = NOP_WORD;
            wr_ptr_next    = wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == LAST_IDX) begin
               state_next = DONE;
            end
         end
         DONE, ERROR: begin
            if (restart) begin
               state_next = LEN;
            end
         end
         default: begin
            state_next = LEN;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
   import proc_pkg::*;

`ifdef LOADER_NOP_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   typedef struct {
      string      name;
      int         len;
      bit         fixed;     // use the fixed 4-byte program
      logic [7:0] csum;      // checksum to send when calc == 0
      bit         calc;      // send the correct checksum
      int         bubbles;   // idle cycles before each data/csum byte
      bit         exp_done;
   } vec_t;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       restart = 1'b0;
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       done;
   logic       error;

   instr_loader_if bus ();

   instr_loader dut (
      .clk       (clk),
      .reset     (reset),
      .s_in      (bus),
      .restart   (restart),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   logic [7:0] fixed_bytes [4] = '{8'h05, 8'h13, 8'h61, 8'hB9};
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check($sformatf("write_addr[%0d]", e.addr), 32'(mem_addr), 32'(e.addr));
            check($sformatf("write_data[%0d]", e.addr), 32'(mem_wdata), 32'(e.data));
            $display("write addr=%0d data=%02h", mem_addr, mem_wdata);
         end
      end
   end

   task automatic send(input logic [7:0] b, input int bubbles);
      int  t;
      bit  sent;
      repeat (bubbles) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      t = 0;
      sent = 0;
      while (!sent && t < 50) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = b;
         if (bus.in_ready === 1'b1) begin
            @(posedge clk);
            sent = 1;
         end
         t++;
      end
      if (!sent) begin
         check("send_timeout", 32'(t), 32'd0);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_status(output int lat);
      lat = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat = k;
         if (done === 1'b1 || error === 1'b1) break;
      end
   endtask

   task automatic pulse_restart(input string name);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check({name, "_restart_ready"}, 32'(bus.in_ready), 32'd1);
      check({name, "_restart_done"}, 32'(done), 32'd0);
      check({name, "_restart_error"}, 32'(error), 32'd0);
      check({name, "_restart_cpu_reset"}, 32'(cpu_reset), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] b;
      logic [7:0] sum;
      int         lat;
      int         exp_lat;
      sum = 8'h00;
      send(8'(v.len), 0);
      if (v.len >= 1 && v.len <= 32) begin
         for (int i = 0; i < v.len; i++) begin
            b = v.fixed ? fixed_bytes[i] : 8'($urandom);
            exp_q.push_back('{addr: 5'(i), data: b});
            sum = sum + b;
            send(b, v.bubbles);
         end
         b = v.calc ? sum : v.csum;
         if (v.exp_done && FILL_EN) begin
            for (int a = v.len; a < 32; a++) exp_q.push_back('{addr: 5'(a), data: 8'hC0});
         end
         send(b, v.bubbles);
      end
      wait_status(lat);
      exp_lat = (v.exp_done && FILL_EN) ? 32 - v.len : 0;
      check({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({v.name, "_done"}, 32'(done), 32'(v.exp_done));
      check({v.name, "_error"}, 32'(error), 32'(!v.exp_done));
      check({v.name, "_cpu_reset"}, 32'(cpu_reset), 32'(!v.exp_done));
      check({v.name, "_ready"}, 32'(bus.in_ready), 32'd0);
      repeat (2) @(negedge clk);
      check({v.name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      $display("frame %s len=%0d done=%0b error=%0b latency=%0d", v.name, v.len, done, error, lat);
      pulse_restart(v.name);
   endtask

   initial begin
      vecs[0] = '{name: "good4",    len: 4,  fixed: 1, csum: 8'h32, calc: 0, bubbles: 0, exp_done: 1};
      vecs[1] = '{name: "badcsum",  len: 4,  fixed: 1, csum: 8'h33, calc: 0, bubbles: 0, exp_done: 0};
      vecs[2] = '{name: "len0",     len: 0,  fixed: 0, csum: 8'h00, calc: 0, bubbles: 0, exp_done: 0};
      vecs[3] = '{name: "len33",    len: 33, fixed: 0, csum: 8'h00, calc: 0, bubbles: 0, exp_done: 0};
      vecs[4] = '{name: "len32",    len: 32, fixed: 0, csum: 8'h00, calc: 1, bubbles: 0, exp_done: 1};
      vecs[5] = '{name: "bubbles2", len: 2,  fixed: 0, csum: 8'h00, calc: 1, bubbles: 1, exp_done: 1};
      vecs[6] = '{name: "len1",     len: 1,  fixed: 0, csum: 8'h00, calc: 1, bubbles: 0, exp_done: 1};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Restart is ignored outside DONE/ERROR: pulse it in LEN, then run a frame.
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_in_len_ready", 32'(bus.in_ready), 32'd1);
      check("restart_in_len_cpu_reset", 32'(cpu_reset), 32'd1);

      // Reset in the middle of DATA, after the second data byte.
      send(8'd4, 0);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{addr: 5'(i), data: fixed_bytes[i]});
         send(fixed_bytes[i], 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      $display("reset applied mid-frame, reloading");
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
